// File: rtl/alu_shift_pkg.sv
// alu_shift_pkg: opcode encodings and the shift-amount split across pipeline stages
package alu_shift_pkg;

    localparam logic [2:0] OPC_SLL = 3'b001;
    localparam logic [2:0] OPC_SAR = 3'b010;
    localparam logic [2:0] OPC_ROL = 3'b011;
    localparam logic [2:0] OPC_ROR = 3'b100;
    localparam logic [2:0] OPC_SRL = 3'b101;

    typedef enum logic [2:0] {
        OP_SLL = OPC_SLL,
        OP_SAR = OPC_SAR,
        OP_ROL = OPC_ROL,
        OP_ROR = OPC_ROR,
        OP_SRL = OPC_SRL
    } op_e;

    // bit mask of the shift-amount bits handled by stage idx: LSB first, ceil-divided chunks, last stage gets the remainder
    function automatic int stage_mask(input int idx, input int lg, input int stages);
        int chunk;
        chunk = (lg + stages - 1) / stages;
        return (((1 << chunk) - 1) << (idx * chunk)) & ((1 << lg) - 1);
    endfunction

endpackage

// File: rtl/alu_shift_pipe_if.sv
// alu_shift_pipe_if: request/response bus of the pipelined shifter
interface alu_shift_pipe_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       opcode;
    logic             en;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] result;
    logic             illegal;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output A, B, opcode, en, in_valid, out_ready,
        input  in_ready, result, illegal, out_valid
    );

    modport slave (
        input  A, B, opcode, en, in_valid, out_ready,
        output in_ready, result, illegal, out_valid
    );
endinterface

// File: rtl/alu_shift_stage.sv
// alu_shift_stage: one pipeline stage, partial shift by its slice of the shift amount plus payload register
module alu_shift_stage
    import alu_shift_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int IDX    = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     hold,
    input  logic                     v_i,
    input  logic [WIDTH-1:0]         val_i,
    input  logic [$clog2(WIDTH)-1:0] shamt_i,
    input  op_e                      op_i,
    input  logic                     ill_i,
    input  logic                     ovf_i,
    output logic                     v_o,
    output logic [WIDTH-1:0]         val_o,
    output logic [$clog2(WIDTH)-1:0] shamt_o,
    output op_e                      op_o,
    output logic                     ill_o,
    output logic                     ovf_o
);
    localparam int LG = $clog2(WIDTH);
    localparam logic [LG-1:0] SLICE = LG'(stage_mask(IDX, LG, STAGES));

    logic [LG-1:0]           amt, shamt_d, shamt_q;
    logic [WIDTH-1:0]        sll, srl, val_d, val_q;
    logic signed [WIDTH-1:0] sar;
`ifdef ALU_SHIFT_PIPE_ROTATE_EN
    logic [WIDTH-1:0]        rol, ror;
`endif
    logic                    v_d, v_q, ill_d, ill_q, ovf_d, ovf_q;
    op_e                     op_d, op_q;

    // partial shift by this stage's bits; illegal forces 0, overshift fills, stall holds everything
    always_comb begin
        amt = shamt_i & SLICE;
        sll = val_i << amt;
        srl = val_i >> amt;
        sar = $signed(val_i) >>> amt;
`ifdef ALU_SHIFT_PIPE_ROTATE_EN
        rol = (val_i << amt) | (val_i >> (WIDTH - int'(amt)));
        ror = (val_i >> amt) | (val_i << (WIDTH - int'(amt)));
`endif
        v_d     = hold ? v_q : v_i;
        shamt_d = hold ? shamt_q : shamt_i;
        op_d    = hold ? op_q : op_i;
        ill_d   = hold ? ill_q : ill_i;
        ovf_d   = hold ? ovf_q : ovf_i;
        val_d   = hold             ? val_q :
                  ill_i            ? '0 :
                  op_i == OP_SLL   ? (ovf_i ? '0 : sll) :
                  op_i == OP_SRL   ? (ovf_i ? '0 : srl) :
                  op_i == OP_SAR   ? (ovf_i ? {WIDTH{val_i[WIDTH-1]}} : sar) :
`ifdef ALU_SHIFT_PIPE_ROTATE_EN
                  op_i == OP_ROL   ? rol :
                  op_i == OP_ROR   ? ror :
`endif
                  '0;
    end

    // stage register; reset empties the slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q     <= 1'b0;
            val_q   <= '0;
            shamt_q <= '0;
            op_q    <= OP_SLL;
            ill_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            v_q     <= v_d;
            val_q   <= val_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
            ill_q   <= ill_d;
            ovf_q   <= ovf_d;
        end
    end

    assign v_o     = v_q;
    assign val_o   = val_q;
    assign shamt_o = shamt_q;
    assign op_o    = op_q;
    assign ill_o   = ill_q;
    assign ovf_o   = ovf_q;
endmodule

// File: rtl/alu_shift_pipe.sv
// alu_shift_pipe: pipelined SLL/SRL/SAR shifter with valid/ready handshake; ROL/ROR when ALU_SHIFT_PIPE_ROTATE_EN is defined
module alu_shift_pipe
    import alu_shift_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input logic             clk,
    input logic             rst_n,
    alu_shift_pipe_if.slave bus
);
    localparam int LG = $clog2(WIDTH);

    logic             hold, legal, ovf, unused_tail;
    logic             v     [STAGES+1];
    logic [WIDTH-1:0] val   [STAGES+1];
    logic [LG-1:0]    shamt [STAGES+1];
    op_e              op    [STAGES+1];
    logic             ill   [STAGES+1];
    logic             ovfs  [STAGES+1];

    // stall and acceptance, opcode legality, overshift when any bit above the log2 range is set
    always_comb begin
        hold         = bus.out_valid && !bus.out_ready;
        bus.in_ready = rst_n && bus.en && !hold;
`ifdef ALU_SHIFT_PIPE_ROTATE_EN
        legal        = bus.opcode inside {OPC_SLL, OPC_SAR, OPC_ROL, OPC_ROR, OPC_SRL};
`else
        legal        = bus.opcode inside {OPC_SLL, OPC_SAR, OPC_SRL};
`endif
        ovf          = |(bus.B >> LG);
    end

    assign v[0]     = bus.in_valid && bus.in_ready;
    assign val[0]   = bus.A;
    assign shamt[0] = bus.B[LG-1:0];
    assign op[0]    = op_e'(bus.opcode);
    assign ill[0]   = !legal;
    assign ovfs[0]  = ovf;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        alu_shift_stage #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES),
            .IDX    (i)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .hold    (hold),
            .v_i     (v[i]),
            .val_i   (val[i]),
            .shamt_i (shamt[i]),
            .op_i    (op[i]),
            .ill_i   (ill[i]),
            .ovf_i   (ovfs[i]),
            .v_o     (v[i+1]),
            .val_o   (val[i+1]),
            .shamt_o (shamt[i+1]),
            .op_o    (op[i+1]),
            .ill_o   (ill[i+1]),
            .ovf_o   (ovfs[i+1])
        );
    end

    assign bus.out_valid = v[STAGES];
    assign bus.result    = val[STAGES];
    assign bus.illegal   = ill[STAGES];
    assign unused_tail   = ^{shamt[STAGES], op[STAGES], ovfs[STAGES]};
endmodule

// File: tb/tb_alu_shift_pipe.sv
// tb_alu_shift_pipe: directed and random stimulus for alu_shift_pipe checked against a whole-word shift model
module tb_alu_shift_pipe;
    localparam int W = 32;
    localparam int S = 2;

    typedef struct {
        logic [W-1:0] res;
        logic         ill;
        int           adv;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    exp_t q [$];
    int checks = 0;
    int errors = 0;
    int accepted = 0;
    bit live = 1'b0;
    bit stalled = 1'b0;
    logic [W-1:0] held_res;
    logic held_ill;

    alu_shift_pipe_if #(.WIDTH(W)) bus ();

    alu_shift_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        logic [2*W-1:0] d;
        logic [W-1:0] res;
        logic ill;
        longint s;
        int r;
        r = int'(b % W);
        d = {a, a};
        s = $signed(a);
        res = '0;
        ill = 1'b0;
        case (op)
            3'b001: res = b >= W ? '0 : a << b;
            3'b101: res = b >= W ? '0 : a >> b;
            3'b010: begin
                s = s >>> (b >= W ? W : b);
                res = s[W-1:0];
            end
`ifdef ALU_SHIFT_PIPE_ROTATE_EN
            3'b011: begin
                d = d << r;
                res = d[2*W-1:W];
            end
            3'b100: begin
                d = d >> r;
                res = d[W-1:0];
            end
`endif
            default: ill = 1'b1;
        endcase
        return {ill, res};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        bus.in_valid = v;
        bus.A = a;
        bus.B = b;
        bus.opcode = op;
    endtask

    // one clock: sample at negedge, check against the model, advance the model, return 1 after the next posedge
    task automatic tick();
        logic vis, rdy, fire;
        logic [W:0] m;
        @(negedge clk);
        vis = q.size() > 0 && q[0].adv >= S;
        rdy = rst_n && bus.en && (bus.out_ready || !vis);
        fire = bus.in_valid && rdy;
        if (live) begin
            chk("out_valid", {63'b0, bus.out_valid}, {63'b0, vis});
            chk("in_ready", {63'b0, bus.in_ready}, {63'b0, rdy});
            if (vis) begin
                chk("result", {32'b0, bus.result}, {32'b0, q[0].res});
                chk("illegal", {63'b0, bus.illegal}, {63'b0, q[0].ill});
            end
            if (stalled) begin
                chk("stall_result", {32'b0, bus.result}, {32'b0, held_res});
                chk("stall_illegal", {63'b0, bus.illegal}, {63'b0, held_ill});
            end
        end
        stalled = rst_n && vis && !bus.out_ready;
        held_res = bus.result;
        held_ill = bus.illegal;
        if (!rst_n) q.delete();
        else if (!stalled) begin
            if (vis) void'(q.pop_front());
            for (int i = 0; i < q.size(); i++) q[i].adv++;
            if (fire) begin
                m = model(bus.A, bus.B, bus.opcode);
                q.push_back('{res: m[W-1:0], ill: m[W], adv: 1});
                accepted++;
            end
        end
        live = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        logic [2:0] ops [3];
        ops[0] = 3'b001;
        ops[1] = 3'b010;
        ops[2] = 3'b101;
        bus.en = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b0, '0, '0, 3'b000);
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("rst_result", {32'b0, bus.result}, 64'd0);
        chk("rst_illegal", {63'b0, bus.illegal}, 64'd0);
        // SLL with exact two-cycle latency
        drive(1'b1, 32'h0000_00F0, 32'd4, 3'b001);
        tick();
        drive(1'b0, '0, '0, 3'b000);
        repeat (3) tick();
        // overshift SAR / SRL
        drive(1'b1, 32'h8000_0000, 32'd40, 3'b010);
        tick();
        drive(1'b1, 32'h8000_0000, 32'd40, 3'b101);
        tick();
        // rotates (illegal when the rotate build is off)
        drive(1'b1, 32'h8000_0001, 32'd33, 3'b011);
        tick();
        drive(1'b1, 32'h8000_0001, 32'd1, 3'b100);
        tick();
        drive(1'b1, 32'h8000_0001, 32'd64, 3'b011);
        tick();
        // illegal opcode, then en low blocks acceptance
        drive(1'b1, 32'h1234_5678, 32'd3, 3'b111);
        tick();
        bus.en = 1'b0;
        drive(1'b1, 32'hDEAD_BEEF, 32'd1, 3'b001);
        repeat (2) tick();
        chk("en_low_in_ready", {63'b0, bus.in_ready}, 64'd0);
        bus.en = 1'b1;
        drive(1'b0, '0, '0, 3'b000);
        repeat (3) tick();
        // five back-to-back requests with out_ready low for three cycles
        base = accepted;
        for (int i = 0; i < 12; i++) begin
            bus.out_ready = !(i >= 2 && i <= 4);
            drive(accepted - base < 5, $urandom, $urandom_range(0, 40), ops[i % 3]);
            tick();
        end
        // reset with two requests in flight
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h0F0F_0F0F, 32'd2, 3'b001);
        tick();
        drive(1'b1, 32'hF0F0_F0F0, 32'd3, 3'b101);
        tick();
        rst_n = 1'b0;
        drive(1'b1, 32'h1111_1111, 32'd1, 3'b001);
        tick();
        rst_n = 1'b1;
        chk("midrst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("midrst_result", {32'b0, bus.result}, 64'd0);
        drive(1'b1, 32'h0000_0003, 32'd31, 3'b001);
        tick();
        drive(1'b0, '0, '0, 3'b000);
        repeat (3) tick();
        // random traffic
        for (int i = 0; i < 600; i++) begin
            rst_n = $urandom_range(0, 99) != 0;
            bus.en = $urandom_range(0, 9) != 0;
            bus.out_ready = $urandom_range(0, 3) != 0;
            drive($urandom_range(0, 3) != 0, $urandom,
                  $urandom_range(0, 1) ? $urandom_range(0, W - 1) : $urandom,
                  3'($urandom_range(0, 7)));
            tick();
        end
        rst_n = 1'b1;
        bus.en = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, '0, '0, 3'b000);
        repeat (6) tick();
        chk("drained_out_valid", {63'b0, bus.out_valid}, 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
